// File: rtl/ring_meas_ctrl.sv
// Ring-oscillator bank measurement controller: settle, gate-count, report.
// Define RING_SCAN_EN to add i_scan for back-to-back measurement of all rings.
module ring_meas_ctrl #(
  parameter int pRINGS     = 5,
  parameter int pGATE_BITS = 10,
  parameter int pCNT_BITS  = 16,
  parameter int pSETTLE    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [pRINGS-1:0]    i_ring,
  input  logic                 i_start,
  input  logic [2:0]           i_sel,
`ifdef RING_SCAN_EN
  input  logic                 i_scan,
`endif
  output logic [pRINGS-1:0]    o_en,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [pCNT_BITS-1:0] o_count,
  output logic                 o_ovf,
  output logic                 o_err,
  output logic [2:0]           o_id
);

  localparam int SW = $clog2(pSETTLE + 1);
  localparam int CW = ((pGATE_BITS > SW) ? pGATE_BITS : SW) + 1;
  localparam logic [CW-1:0] SET_LAST  = CW'(pSETTLE - 1);
  localparam logic [CW-1:0] GATE_LAST = CW'((64'd1 << pGATE_BITS) - 64'd1);
  localparam logic [2:0]    LAST_IDX  = 3'(pRINGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [pCNT_BITS-1:0] cnt_q, cnt_d;
  logic sat_q, sat_d;
  logic [pCNT_BITS-1:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic err_q, err_d;
  logic [2:0] id_q, id_d;
`ifdef RING_SCAN_EN
  logic scan_q, scan_d;
`endif

  logic [pRINGS-1:0] s1_q, s2_q, s3_q;
  logic [pRINGS-1:0] rise;
  logic [pRINGS-1:0] en_vec;
  logic hit;
  logic sel_ok;

  // s1/s2 resolve metastability, s3 holds the previous value for edge detect
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= i_ring;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise   = s2_q & ~s3_q;
  assign en_vec = pRINGS'(1) << idx_q;
  assign hit    = |(rise & en_vec);
  assign sel_ok = 32'(i_sel) < 32'(pRINGS);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    id_d    = id_q;
`ifdef RING_SCAN_EN
    scan_d  = scan_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef RING_SCAN_EN
        if (i_scan) begin
          idx_d   = 3'd0;
          scan_d  = 1'b1;
          cnt_d   = '0;
          sat_d   = 1'b0;
          cyc_d   = '0;
          state_d = SETTLE;
        end else
`endif
        if (i_start) begin
          idx_d = i_sel;
          cnt_d = '0;
          sat_d = 1'b0;
          cyc_d = '0;
          if (sel_ok) begin
            state_d = SETTLE;
          end else begin
            state_d = DONE;
            count_d = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            id_d    = i_sel;
          end
        end
      end
      SETTLE: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == SET_LAST) begin
          cyc_d   = '0;
          state_d = GATE;
        end
      end
      GATE: begin
        cyc_d = cyc_q + 1'b1;
        if (hit) begin
          if (cnt_q == '1) sat_d = 1'b1;
          else             cnt_d = cnt_q + 1'b1;
        end
        // result registers load as DONE is entered so they are valid with o_done
        if (cyc_q == GATE_LAST) begin
          state_d = DONE;
          count_d = cnt_d;
          ovf_d   = sat_d;
          err_d   = 1'b0;
          id_d    = idx_q;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef RING_SCAN_EN
        if (scan_q && i_scan && (idx_q != LAST_IDX)) begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
          sat_d   = 1'b0;
          cyc_d   = '0;
          state_d = SETTLE;
        end else begin
          scan_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= '0;
`ifdef RING_SCAN_EN
      scan_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      id_q    <= id_d;
`ifdef RING_SCAN_EN
      scan_q  <= scan_d;
`endif
    end
  end

  assign o_en    = ((state_q == SETTLE) || (state_q == GATE)) ? en_vec : '0;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = (state_q == DONE);
  assign o_count = count_q;
  assign o_ovf   = ovf_q;
  assign o_err   = err_q;
  assign o_id    = id_q;

endmodule

// File: tb/tb_ring_meas_ctrl.sv
// Directed bench for ring_meas_ctrl (pGATE_BITS=4, pSETTLE=3, pRINGS=5).
// A second instance with pCNT_BITS=2 covers counter saturation.
module tb_ring_meas_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       scan;
  logic [2:0] sel;
  logic [4:0] ring;
  logic [3:0] rc = 4'd0;

  logic [4:0]  en;
  logic        busy, done, ovf, err;
  logic [15:0] count;
  logic [2:0]  id;

  logic [4:0] s_en;
  logic       s_busy, s_done, s_ovf, s_err;
  logic [1:0] s_count;
  logic [2:0] s_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // free-running rings: r0 period 2, r2 period 4, r3 period 8, r4 period 16
  always @(negedge clk) rc <= rc + 4'd1;
  assign ring = {rc[3], rc[2], rc[1], 1'b0, rc[0]};

  ring_meas_ctrl #(
    .pRINGS(5), .pGATE_BITS(4), .pCNT_BITS(16), .pSETTLE(3)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_ring(ring),
    .i_start(start), .i_sel(sel),
`ifdef RING_SCAN_EN
    .i_scan(scan),
`endif
    .o_en(en), .o_busy(busy), .o_done(done), .o_count(count),
    .o_ovf(ovf), .o_err(err), .o_id(id)
  );

  ring_meas_ctrl #(
    .pRINGS(5), .pGATE_BITS(4), .pCNT_BITS(2), .pSETTLE(3)
  ) u_sat (
    .i_clk(clk), .i_rst(rst), .i_ring(ring),
    .i_start(start), .i_sel(sel),
`ifdef RING_SCAN_EN
    .i_scan(scan),
`endif
    .o_en(s_en), .o_busy(s_busy), .o_done(s_done), .o_count(s_count),
    .o_ovf(s_ovf), .o_err(s_err), .o_id(s_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // issue a request; returns at the negedge just after the accepting edge
  task automatic req(input logic [2:0] s);
    @(negedge clk);
    start = 1'b1;
    sel   = s;
    @(negedge clk);
    start = 1'b0;
    sel   = 3'd1;
  endtask

  task automatic wait_done(input int limit, input logic [4:0] en_exp,
                           output int cyc, output logic en_ok);
    cyc   = 0;
    en_ok = 1'b1;
    while (done !== 1'b1 && cyc < limit) begin
      if (en !== en_exp || busy !== 1'b1) en_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   c;
    logic ok;
    int   np;
    int   id_seen;
    rst   = 1'b1;
    start = 1'b0;
    scan  = 1'b0;
    sel   = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err, 0);
    chk("rst_id", id, 0);
    rst = 1'b0;

    // single measurement of ring 2
    req(3'd2);
    chk("t1_en", en, 5'b00100);
    chk("t1_busy", busy, 1);
    wait_done(40, 5'b00100, c, ok);
    chk("t1_latency", c, 19);
    chk("t1_en_run", ok, 1);
    chk("t1_count", count, 4);
    chk("t1_ovf", ovf, 0);
    chk("t1_err", err, 0);
    chk("t1_id", id, 2);
    chk("t1_en_done", en, 0);
    @(negedge clk);
    chk("t1_done_low", done, 0);
    chk("t1_busy_low", busy, 0);
    chk("t1_count_hold", count, 4);

    // ring 0 at f_clk/2: 8 edges, saturating the 2-bit instance
    req(3'd0);
    wait_done(40, 5'b00001, c, ok);
    chk("t2_latency", c, 19);
    chk("t2_sat_done", s_done, 1);
    chk("t2_sat_count", s_count, 3);
    chk("t2_sat_ovf", s_ovf, 1);
    chk("t2_count", count, 8);
    chk("t2_ovf", ovf, 0);
    @(negedge clk);

    // out-of-range select
    req(3'd6);
    chk("t3_done", done, 1);
    chk("t3_err", err, 1);
    chk("t3_count", count, 0);
    chk("t3_ovf", ovf, 0);
    chk("t3_id", id, 6);
    chk("t3_en", en, 0);
    @(negedge clk);
    chk("t3_done_low", done, 0);
    chk("t3_busy_low", busy, 0);
    chk("t3_en_after", en, 0);

    // second start during GATE of a ring-3 measurement
    req(3'd3);
    repeat (6) @(negedge clk);
    start = 1'b1;
    sel   = 3'd1;
    @(negedge clk);
    start = 1'b0;
    np = 0;
    id_seen = 7;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin
        np++;
        id_seen = int'(id);
      end
      @(negedge clk);
    end
    chk("t4_pulses", np, 1);
    chk("t4_id", id_seen, 3);
    chk("t4_count", count, 2);
    chk("t4_err", err, 0);

    // reset mid-GATE
    req(3'd2);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_en", en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_count", count, 0);
    chk("t5_id", id, 0);
    @(negedge clk);
    rst = 1'b0;
    req(3'd4);
    wait_done(40, 5'b10000, c, ok);
    chk("t5_latency", c, 19);
    chk("t5_en_run", ok, 1);
    chk("t5_new_count", count, 1);
    chk("t5_new_id", id, 4);
    @(negedge clk);

`ifdef RING_SCAN_EN
    begin
      int   k;
      int   last;
      int   first;
      logic busy_ok;
      logic gap_ok;
      logic ids_ok;
      scan = 1'b1;
      @(negedge clk);
      k = 0; np = 0; last = 0; first = -1;
      busy_ok = 1'b1; gap_ok = 1'b1; ids_ok = 1'b1;
      while (np < 5 && k < 200) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (done === 1'b1) begin
          if (int'(id) != np) ids_ok = 1'b0;
          if (np == 0) first = k;
          else if (k - last != 20) gap_ok = 1'b0;
          last = k;
          np++;
          if (np == 5) scan = 1'b0;
        end
        @(negedge clk);
        k++;
      end
      chk("t6_pulses", np, 5);
      chk("t6_first", first, 19);
      chk("t6_gap", gap_ok, 1);
      chk("t6_ids", ids_ok, 1);
      chk("t6_busy", busy_ok, 1);
      chk("t6_busy_end", busy, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
